// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if
// Groups the hazard-detection inputs, D-cache handshake and the pipeline
// control outputs of pipeline_stall_ctrl.
//
// D-cache handshake: DCache_req_i is high for every cycle the MEM stage has
// an access outstanding; DCache_ack_i is high in the single cycle the access
// completes (a hit acks in the request cycle, a miss acks when the fill is
// done). A cycle with req high and ack low is a miss/wait cycle.
//
// Modports:
//   master - pipeline side: drives hazard/cache inputs, consumes controls
//   slave  - stall controller: consumes inputs, drives controls/status
// ---------------------------------------------------------------------------
interface pipeline_stall_ctrl_if;
  logic       ID_EX_MemRead_i;
  logic [4:0] ID_EX_RtAddr_i;
  logic [4:0] IF_ID_RsAddr_i;
  logic [4:0] IF_ID_RtAddr_i;
  logic       Branch_taken_i;
  logic       Jump_i;
  logic       DCache_req_i;
  logic       DCache_ack_i;
  logic       PC_Write_o;
  logic       IF_ID_Write_o;
  logic       IF_ID_Flush_o;
  logic       Ctrl_Bubble_o;
  logic       CacheStall_o;
  logic [1:0] State_o;
  logic       Error_o;

  modport master (
    output ID_EX_MemRead_i, ID_EX_RtAddr_i, IF_ID_RsAddr_i, IF_ID_RtAddr_i,
           Branch_taken_i, Jump_i, DCache_req_i, DCache_ack_i,
    input  PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, Ctrl_Bubble_o,
           CacheStall_o, State_o, Error_o
  );

  modport slave (
    input  ID_EX_MemRead_i, ID_EX_RtAddr_i, IF_ID_RsAddr_i, IF_ID_RtAddr_i,
           Branch_taken_i, Jump_i, DCache_req_i, DCache_ack_i,
    output PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, Ctrl_Bubble_o,
           CacheStall_o, State_o, Error_o
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Central hazard/stall sequencer for the 5-stage MIPS pipeline. Arbitrates
// D-cache miss, load-use hazard and branch/jump flush, and traps a cache
// access that never completes (watchdog).
//
// Parameters:
//   TIMEOUT - cache-wait cycles before the trap; 0 disables the watchdog
//   CNT_W   - width of the stall statistics counters
//
// Ports:
//   clk_i  - clock, all state updates on posedge
//   rst_i  - synchronous active-high reset
//   bus    - pipeline_stall_ctrl_if.slave (hazard inputs, cache handshake,
//            PC/IF_ID write enables, flush, bubble, freeze, State_o, Error_o)
//
// Optional feature, macro STALL_CNT_EN:
//   adds StallCache_o / StallHazard_o / FlushCnt_o (CNT_W each), counting
//   miss, load-use stall and flush cycles; saturating, frozen in ERR.
//
// Stall outputs are combinational so a miss freezes the pipe in the very
// cycle it is seen; State_o and Error_o are registered.
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pipeline_stall_ctrl_if.slave bus
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]     StallCache_o,
  output logic [CNT_W-1:0]     StallHazard_o,
  output logic [CNT_W-1:0]     FlushCnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HAZARD = 2'b01,
    ST_CACHE  = 2'b10,
    ST_ERR    = 2'b11
  } state_e;

  localparam int unsigned WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] TO_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic WD_EN = (TIMEOUT != 0);

  state_e         state_q;
  logic [WCW-1:0] wait_cnt_q;
  logic           error_q;

  logic miss;
  logic load_use;
  logic cache_wait;
  logic hazard_stall;
  logic flush_act;

  assign miss = bus.DCache_req_i & ~bus.DCache_ack_i;

  assign load_use = bus.ID_EX_MemRead_i & (bus.ID_EX_RtAddr_i != 5'd0) &
                    ((bus.ID_EX_RtAddr_i == bus.IF_ID_RsAddr_i) |
                     (bus.ID_EX_RtAddr_i == bus.IF_ID_RtAddr_i));

  // While waiting in CACHE the freeze holds until ack even if the request
  // line were to drop, so the pipe never advances over an unfinished access.
  assign cache_wait   = miss | ((state_q == ST_CACHE) & ~bus.DCache_ack_i);
  assign hazard_stall = load_use & ~cache_wait;
  assign flush_act    = (bus.Branch_taken_i | bus.Jump_i) & ~cache_wait & ~load_use;

  // Control outputs, priority: reset > ERR > miss > load_use > flush.
  always_comb begin
    bus.PC_Write_o    = 1'b1;
    bus.IF_ID_Write_o = 1'b1;
    bus.IF_ID_Flush_o = 1'b0;
    bus.Ctrl_Bubble_o = 1'b0;
    bus.CacheStall_o  = 1'b0;
    if (rst_i) begin
      bus.PC_Write_o    = 1'b0;
      bus.IF_ID_Write_o = 1'b0;
      bus.IF_ID_Flush_o = 1'b1;
      bus.Ctrl_Bubble_o = 1'b1;
    end else if (state_q == ST_ERR || cache_wait) begin
      bus.PC_Write_o    = 1'b0;
      bus.IF_ID_Write_o = 1'b0;
      bus.CacheStall_o  = 1'b1;
    end else if (hazard_stall) begin
      bus.PC_Write_o    = 1'b0;
      bus.IF_ID_Write_o = 1'b0;
      bus.Ctrl_Bubble_o = 1'b1;
    end else if (flush_act) begin
      bus.IF_ID_Flush_o = 1'b1;
    end
  end

  // State machine with watchdog counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_CACHE: begin
          if (bus.DCache_ack_i) begin
            state_q <= ST_RUN;
          end else if (WD_EN && wait_cnt_q == TO_LAST) begin
            state_q <= ST_ERR;
            error_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          // RUN and HAZARD share transitions; a load-use seen in HAZARD
          // is simply a fresh hazard.
          if (miss) begin
            state_q    <= ST_CACHE;
            wait_cnt_q <= '0;
          end else if (load_use) begin
            state_q <= ST_HAZARD;
          end else begin
            state_q <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign bus.State_o = state_q;
  assign bus.Error_o = error_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_cache_q;
  logic [CNT_W-1:0] cnt_hazard_q;
  logic [CNT_W-1:0] cnt_flush_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_cache_q  <= '0;
      cnt_hazard_q <= '0;
      cnt_flush_q  <= '0;
    end else if (state_q != ST_ERR) begin
      if (cache_wait && !(&cnt_cache_q))
        cnt_cache_q <= cnt_cache_q + 1'b1;
      if (hazard_stall && !(&cnt_hazard_q))
        cnt_hazard_q <= cnt_hazard_q + 1'b1;
      if (flush_act && !(&cnt_flush_q))
        cnt_flush_q <= cnt_flush_q + 1'b1;
    end
  end

  assign StallCache_o  = cnt_cache_q;
  assign StallHazard_o = cnt_hazard_q;
  assign FlushCnt_o    = cnt_flush_q;
`endif

endmodule
